// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared decode constants, bundle type and field helpers for id_stage
package id_pkg;

    localparam int DATA_W = 32;

    // Field positions within the 32-bit instruction word
    localparam int OPC_LSB  = 25;
    localparam int RD_LSB   = 22;
    localparam int RS1_LSB  = 19;
    localparam int RS2_LSB  = 16;
    localparam int COND_LSB = 21;

    // Opcodes
    localparam logic [6:0] OP_B     = 7'b1100000;
    localparam logic [6:0] OP_BCOND = 7'b1100001;
    localparam logic [6:0] OP_BR    = 7'b1100010;
    localparam logic [6:0] OP_LOAD  = 7'b1000000;
    localparam logic [6:0] OP_STORE = 7'b1000010;

    // Condition codes for OP_BCOND; anything else means always
    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_LT = 4'd2;
    localparam logic [3:0] COND_GE = 4'd3;

    // NZCV flag bit positions
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_HAZ = 1'b1
    } haz_state_t;

    typedef struct packed {
        logic [6:0]        opcode;
        logic [2:0]        rd;
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic              reg_we;
        logic              mem_rd;
        logic              mem_wr;
    } bundle_t;

    function automatic logic is_alu(input logic [6:0] opc);
        return opc[6:5] == 2'b00;
    endfunction

    // Source registers that actually feed the instruction; only these can
    // create a load-use dependency.
    function automatic logic reads_rs1(input logic [6:0] opc);
        return is_alu(opc) || opc == OP_LOAD || opc == OP_STORE || opc == OP_BR;
    endfunction

    // Opcode bit 0 selects the immediate as operand B, so rs2 is unused then.
    function automatic logic reads_rs2(input logic [6:0] opc);
        return (is_alu(opc) && !opc[0]) || opc == OP_STORE;
    endfunction

endpackage

// File: rtl/id_cond_eval.sv
// rtl/id_cond_eval.sv - combinational branch condition evaluation against NZCV flags
module id_cond_eval
    import id_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    // Carry does not participate in any supported condition
    logic unused_carry;
    assign unused_carry = flags[1];

    // Select the flag test named by the condition code
    always_comb begin
        taken = 1'b1;
        case (cond)
            COND_EQ: taken = flags[FLAG_Z];
            COND_NE: taken = !flags[FLAG_Z];
            COND_LT: taken = flags[FLAG_N] ^ flags[FLAG_V];
            COND_GE: taken = !(flags[FLAG_N] ^ flags[FLAG_V]);
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - instruction decode stage with forwarding, branch resolve and load-use stall
module id_stage
    import id_pkg::*;
#(
    parameter int FLUSH_DEPTH = 1,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic [2:0]      rs1_addr,
    output logic [2:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            write_enable,
    input  logic [2:0]      write_addr,
    input  logic [XLEN-1:0] write_value,
    input  logic [3:0]      flags_in,
    input  logic            ex_stall,
    output logic            stall_if,
    output logic            br_taken,
    output logic [XLEN-1:0] br_target,
    output logic            ex_valid,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_rd,
    output logic [XLEN-1:0] ex_op_a,
    output logic [XLEN-1:0] ex_op_b,
    output logic            ex_reg_we,
    output logic            ex_mem_rd,
    output logic            ex_mem_wr
);

    localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_DEPTH);

    haz_state_t      state;
    haz_state_t      state_next;
    logic [7:0]      flush_cnt;
    bundle_t         dec;
    bundle_t         ex_q;

    logic [6:0]      opcode;
    logic [3:0]      cond;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic            is_nop;
    logic            flushing;
    logic            load_use;
    logic            cond_taken;
    logic            issue_bubble;
    logic            take_branch;

    assign opcode   = instr_in[OPC_LSB +: 7];
    assign cond     = instr_in[COND_LSB +: 4];
    assign rs1_addr = instr_in[RS1_LSB +: 3];
    assign rs2_addr = instr_in[RS2_LSB +: 3];
    assign imm_ext  = {{(XLEN-16){instr_in[15]}}, instr_in[15:0]};
    assign is_nop   = (instr_in == 32'h0);
    assign flushing = (flush_cnt != 8'd0);

    // Same-cycle write-back wins over the stale register-file read
    assign fwd_a = (write_enable && write_addr == rs1_addr) ? write_value : rs1_data;
    assign fwd_b = (write_enable && write_addr == rs2_addr) ? write_value : rs2_data;

    // The bundle now in execute is a load whose result this instruction needs
    assign load_use = ex_valid && ex_q.mem_rd && !is_nop &&
                      ((reads_rs1(opcode) && ex_q.rd == rs1_addr) ||
                       (reads_rs2(opcode) && ex_q.rd == rs2_addr));

    id_cond_eval u_cond_eval (
        .cond  (cond),
        .flags (flags_in),
        .taken (cond_taken)
    );

    // Decode the current instruction into the bundle it would issue
    always_comb begin
        dec        = '0;
        dec.opcode = opcode;
        dec.rd     = instr_in[RD_LSB +: 3];
        dec.op_a   = fwd_a;
        dec.op_b   = instr_in[OPC_LSB] ? imm_ext : fwd_b;
        dec.reg_we = is_alu(opcode) || opcode == OP_LOAD;
        dec.mem_rd = (opcode == OP_LOAD);
        dec.mem_wr = (opcode == OP_STORE);
    end

    // Hazard FSM next state and issue control, in priority order
    always_comb begin
        state_next   = state;
        issue_bubble = 1'b0;
        take_branch  = 1'b0;
        stall_if     = 1'b0;
        if (ex_stall) begin
            stall_if = 1'b1;
        end else if (flushing) begin
            issue_bubble = 1'b1;
        end else if (state == ST_RUN && load_use) begin
            issue_bubble = 1'b1;
            stall_if     = 1'b1;
            state_next   = ST_HAZ;
        end else begin
            state_next   = ST_RUN;
            issue_bubble = is_nop;
            take_branch  = !is_nop && opcode == OP_BCOND && cond_taken;
        end
    end

    // Hazard state and post-branch flush counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            flush_cnt <= 8'd0;
        end else begin
            state <= state_next;
            if (!ex_stall) begin
                if (take_branch) begin
                    flush_cnt <= FLUSH_LOAD;
                end else if (flushing) begin
                    flush_cnt <= flush_cnt - 8'd1;
                end
            end
        end
    end

    // Registered decode bundle and one-shot redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid  <= 1'b0;
            ex_q      <= '0;
            br_taken  <= 1'b0;
            br_target <= '0;
        end else if (ex_stall) begin
            br_taken <= 1'b0;
        end else begin
            ex_valid <= !issue_bubble;
            ex_q     <= issue_bubble ? bundle_t'('0) : dec;
            br_taken <= take_branch;
            if (take_branch) begin
                br_target <= pc_in + (imm_ext << 2);
            end
        end
    end

    assign ex_opcode = ex_q.opcode;
    assign ex_rd     = ex_q.rd;
    assign ex_op_a   = ex_q.op_a;
    assign ex_op_b   = ex_q.op_b;
    assign ex_reg_we = ex_q.reg_we;
    assign ex_mem_rd = ex_q.mem_rd;
    assign ex_mem_wr = ex_q.mem_wr;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage with a behavioural decode model
module tb_id_stage;
    import id_pkg::*;

    localparam int FLUSH_DEPTH = 1;
    localparam int XLEN        = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [31:0]     instr_in = '0;
    logic [XLEN-1:0] pc_in = '0;
    logic [2:0]      rs1_addr, rs2_addr;
    logic [XLEN-1:0] rs1_data = '0, rs2_data = '0;
    logic            write_enable = 1'b0;
    logic [2:0]      write_addr = '0;
    logic [XLEN-1:0] write_value = '0;
    logic [3:0]      flags_in = '0;
    logic            ex_stall = 1'b0;
    logic            stall_if, br_taken, ex_valid, ex_reg_we, ex_mem_rd, ex_mem_wr;
    logic [XLEN-1:0] br_target, ex_op_a, ex_op_b;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_rd;

    always #5 clk = ~clk;

    id_stage #(.FLUSH_DEPTH(FLUSH_DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .pc_in(pc_in),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .write_enable(write_enable), .write_addr(write_addr), .write_value(write_value),
        .flags_in(flags_in), .ex_stall(ex_stall), .stall_if(stall_if),
        .br_taken(br_taken), .br_target(br_target), .ex_valid(ex_valid),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr)
    );

    typedef struct {
        logic        valid;
        logic [6:0]  opc;
        logic [2:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic        we;
        logic        mr;
        logic        mw;
        logic        bt;
        logic [31:0] tgt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        m_prev;
    exp_t        mon_e;
    int          m_flush = 0;
    logic [31:0] rf[8];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic exp_t zero_exp();
        exp_t z;
        z.valid = 0; z.opc = 0; z.rd = 0; z.a = 0; z.b = 0;
        z.we = 0; z.mr = 0; z.mw = 0; z.bt = 0; z.tgt = 0;
        return z;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] rd,
                                       input logic [2:0] s1, input logic [2:0] s2,
                                       input logic [15:0] imm);
        return {op, rd, s1, s2, imm};
    endfunction

    // Does this instruction read register r as a source operand?
    function automatic bit reads_reg(input logic [31:0] ins, input logic [2:0] r);
        logic [6:0] op;
        op = ins[31:25];
        if (op[6:5] == 2'b00) return (r == ins[21:19]) || (!ins[25] && r == ins[18:16]);
        if (op == OP_LOAD || op == OP_BR) return r == ins[21:19];
        if (op == OP_STORE) return (r == ins[21:19]) || (r == ins[18:16]);
        return 0;
    endfunction

    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        case (c)
            4'd0: return f[2] == 1'b1;
            4'd1: return f[2] == 1'b0;
            4'd2: return f[3] != f[0];
            4'd3: return f[3] == f[0];
            default: return 1;
        endcase
    endfunction

    // Drive one cycle of inputs, predict the next edge's outputs and queue them
    task automatic step(input logic rst, input logic [31:0] ins, input logic [31:0] pc,
                        input logic stl, input logic [3:0] flg, input logic we,
                        input logic [2:0] wa, input logic [31:0] wv, output logic stall_exp);
        exp_t        e;
        logic [31:0] fa, fb;
        logic [2:0]  r1, r2;
        logic [6:0]  op;
        bit          hz;
        @(negedge clk);
        reset = rst; instr_in = ins; pc_in = pc; ex_stall = stl; flags_in = flg;
        write_enable = we; write_addr = wa; write_value = wv;
        r1 = ins[21:19];
        r2 = ins[18:16];
        rs1_data = rf[r1];
        rs2_data = rf[r2];
        op = ins[31:25];
        fa = (we && wa == r1) ? wv : rf[r1];
        fb = (we && wa == r2) ? wv : rf[r2];
        hz = m_prev.valid && m_prev.mr && ins != 0 && reads_reg(ins, m_prev.rd);
        stall_exp = 0;
        if (rst) begin
            e = zero_exp();
            m_flush = 0;
        end else if (stl) begin
            e = m_prev;
            e.bt = 0;
            stall_exp = 1;
        end else if (m_flush > 0 || hz || ins == 0) begin
            e = zero_exp();
            e.tgt = m_prev.tgt;
            if (m_flush > 0) m_flush--;
            else if (hz) stall_exp = 1;
        end else begin
            e = zero_exp();
            e.valid = 1;
            e.opc = op;
            e.rd = ins[24:22];
            e.a = fa;
            e.b = ins[25] ? 32'($signed(ins[15:0])) : fb;
            e.we = (op[6:5] == 2'b00) || op == OP_LOAD;
            e.mr = (op == OP_LOAD);
            e.mw = (op == OP_STORE);
            e.tgt = m_prev.tgt;
            if (op == OP_BCOND && cond_holds(ins[24:21], flg)) begin
                e.bt = 1;
                e.tgt = pc + 32'($signed(ins[15:0])) * 32'd4;
                m_flush = FLUSH_DEPTH;
            end
        end
        #1;
        chk("rs1_addr", 32'(rs1_addr), 32'(r1));
        chk("rs2_addr", 32'(rs2_addr), 32'(r2));
        if (!rst) chk("stall_if", 32'(stall_if), 32'(stall_exp));
        exp_q.push_back(e);
        m_prev = e;
        if (we) rf[wa] = wv;
    endtask

    // Monitor: every clock edge presents a bundle; compare it with the oldest prediction
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("ex_valid", 32'(ex_valid), 32'(mon_e.valid));
                chk("ex_opcode", 32'(ex_opcode), 32'(mon_e.opc));
                chk("ex_rd", 32'(ex_rd), 32'(mon_e.rd));
                chk("ex_op_a", ex_op_a, mon_e.a);
                chk("ex_op_b", ex_op_b, mon_e.b);
                chk("ex_reg_we", 32'(ex_reg_we), 32'(mon_e.we));
                chk("ex_mem_rd", 32'(ex_mem_rd), 32'(mon_e.mr));
                chk("ex_mem_wr", 32'(ex_mem_wr), 32'(mon_e.mw));
                chk("br_taken", 32'(br_taken), 32'(mon_e.bt));
                chk("br_target", br_target, mon_e.tgt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: r = 32'h0;
            1, 2, 3: r[31:30] = 2'b00;
            4: r[31:25] = OP_LOAD;
            5: r[31:25] = OP_STORE;
            6, 7: r[31:25] = OP_BCOND;
            8: r[31:25] = OP_B;
            default: r[31:25] = OP_BR;
        endcase
        return r;
    endfunction

    localparam logic [6:0] OP_ADD = 7'b0000000;

    initial begin
        logic        s;
        logic [31:0] ins, pc, add2, bc;
        logic        rst, stl;
        for (int i = 0; i < 8; i++) rf[i] = 32'h1000 + 32'(i);
        rf[3] = 32'h5;
        m_prev = zero_exp();
        add2 = mk(OP_ADD, 3'd4, 3'd2, 3'd5, 16'h0);

        // Reset held two cycles with a live ALU add on the input
        step(1, mk(OP_ADD, 1, 2, 3, 0), 32'h0, 0, 0, 0, 0, 0, s);
        step(1, mk(OP_ADD, 1, 2, 3, 0), 32'h0, 0, 0, 0, 0, 0, s);
        @(posedge clk); #2;
        chk("reset_valid", 32'(ex_valid), 0);
        chk("reset_stall_if", 32'(stall_if), 0);

        // Forwarding of same-cycle write-back onto rs1
        step(0, mk(OP_ADD, 1, 3, 4, 0), 32'h10, 0, 0, 1, 3, 32'h77, s);
        @(posedge clk); #2;
        chk("fwd_op_a", ex_op_a, 32'h77);
        chk("first_valid", 32'(ex_valid), 1);

        // Load-use: one bubble, then the held add issues
        step(0, mk(OP_LOAD, 2, 1, 0, 16'h10), 32'h14, 0, 0, 0, 0, 0, s);
        step(0, add2, 32'h18, 0, 0, 0, 0, 0, s);
        chk("lu_stall_if", 32'(stall_if), 1);
        @(posedge clk); #2;
        chk("lu_bubble", 32'(ex_valid), 0);
        step(0, add2, 32'h18, 0, 0, 1, 2, 32'hABCD, s);
        chk("lu_release", 32'(stall_if), 0);
        @(posedge clk); #2;
        chk("lu_issue_rd", 32'(ex_rd), 4);
        chk("lu_issue_a", ex_op_a, 32'hABCD);

        // Taken BCOND EQ with Z set, backward offset
        bc = {OP_BCOND, 4'h0, 5'h0, 16'hFFFE};
        step(0, bc, 32'h100, 0, 4'b0100, 0, 0, 0, s);
        @(posedge clk); #2;
        chk("bc_taken", 32'(br_taken), 1);
        chk("bc_target", br_target, 32'hF8);
        step(0, mk(OP_ADD, 1, 1, 1, 0), 32'h104, 0, 0, 0, 0, 0, s);
        @(posedge clk); #2;
        chk("bc_flush_bubble", 32'(ex_valid), 0);
        chk("bc_pulse_end", 32'(br_taken), 0);
        step(0, mk(OP_ADD, 1, 1, 1, 0), 32'hF8, 0, 0, 0, 0, 0, s);

        // Not-taken BCOND EQ with Z clear
        step(0, bc, 32'h200, 0, 4'b0000, 0, 0, 0, s);
        @(posedge clk); #2;
        chk("nt_taken", 32'(br_taken), 0);
        step(0, mk(OP_ADD, 5, 1, 1, 0), 32'h204, 0, 0, 0, 0, 0, s);
        @(posedge clk); #2;
        chk("nt_next_valid", 32'(ex_valid), 1);

        // Execute stall for three cycles right after a taken branch
        step(0, bc, 32'h300, 0, 4'b0100, 0, 0, 0, s);
        for (int k = 0; k < 3; k++) step(0, mk(OP_ADD, 6, 1, 1, 0), 32'h304, 1, 4'b0100, 0, 0, 0, s);
        @(posedge clk); #2;
        chk("st_no_repeat", 32'(br_taken), 0);
        chk("st_hold_opc", 32'(ex_opcode), 32'(OP_BCOND));
        step(0, mk(OP_ADD, 6, 1, 1, 0), 32'h304, 0, 0, 0, 0, 0, s);

        // Randomised traffic with fetch holding on predicted stalls
        ins = rand_instr();
        pc = $urandom;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            stl = !rst && ($urandom_range(0, 6) == 0);
            step(rst, ins, pc, stl, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), $urandom, s);
            if (!s) begin
                ins = rand_instr();
                pc = $urandom;
            end
        end

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction Decode stage, directly downstream of instruction fetch. It consumes the 32-bit fetched instruction and its PC.
- Reads the 8-entry register file, forwarding the same-cycle write-back value. Resolves conditional branches and detects load-use hazards.
- Emits one registered decode bundle per cycle to execute. Redirect and stall requests go back to fetch.

Parameters:
- FLUSH_DEPTH, 1, number of in-flight fetched instructions squashed after a taken conditional branch (fetch prefetch depth).
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- instr_in  in  32  instruction from fetch; 32'h0 is a NOP/bubble.
- pc_in  in  XLEN  PC of instr_in.
- rs1_addr  out  3  register-file read address A = instr_in[21:19] (combinational).
- rs2_addr  out  3  register-file read address B = instr_in[18:16] (combinational).
- rs1_data  in  XLEN  register-file read data A.
- rs2_data  in  XLEN  register-file read data B.
- write_enable  in  1  write-back strobe.
- write_addr  in  3  write-back register.
- write_value  in  XLEN  write-back data.
- flags_in  in  4  NZCV flags.
- ex_stall  in  1  execute cannot accept a new bundle.
- stall_if  out  1  fetch must hold PC and instruction (combinational).
- br_taken  out  1  one-cycle redirect pulse (registered).
- br_target  out  XLEN  redirect PC (registered).
- ex_valid  out  1  bundle valid.
- ex_opcode  out  7  instr[31:25].
- ex_rd  out  3  instr[24:22].
- ex_op_a  out  XLEN  forwarded rs1 value.
- ex_op_b  out  XLEN  forwarded rs2 value, or sign-extended imm16 when instr[25]=1.
- ex_reg_we  out  1  instruction writes rd.
- ex_mem_rd  out  1  load.
- ex_mem_wr  out  1  store.

Behaviour:
- Field layout:
  - opcode [31:25], rd [24:22], rs1 [21:19], rs2 [18:16], imm16 [15:0].
  - Conditional-branch cond [24:21].
  - Opcodes come from the package: OP_B=1100000, OP_BCOND=1100001, OP_BR=1100010, OP_LOAD=1000000, OP_STORE=1000010, ALU class opcode[31:30]=00.
- Reset (clk edge with reset=1): every registered output is 0; state=RUN; flush_cnt=0; last-load tracker cleared. Reset mid-stall or mid-flush abandons it.
- Latency: a decode bundle appears on ex_* one cycle after instr_in is accepted.
- Forwarding: when write_enable=1 and write_addr equals rs1 (or rs2), write_value replaces rs1_data (or rs2_data).
- B and BR are resolved in fetch. Here they decode as ex_valid=1 with reg_we, mem_rd and mem_wr all 0.
- OP_BCOND:
  - cond is evaluated against flags_in: EQ=0, NE=1, LT=2, GE=3, others=always.
  - If taken: br_taken=1 for exactly one cycle; br_target = pc_in + (sext(imm16)<<2), width XLEN, wrap-around modulo 2^32; flush_cnt loads FLUSH_DEPTH.
  - If not taken: nothing happens beyond the bundle.
- Flush: while flush_cnt>0, each accepted instr_in is issued as a bubble (ex_valid=0, all ex_* control 0) and flush_cnt decrements. A bubble never triggers a branch or a hazard.
- Load-use hazard FSM, states RUN and HAZ:
  - RUN->HAZ when the bundle issued last cycle has ex_mem_rd=1 and its ex_rd equals the rs1 or rs2 of the current instr_in (only the fields the opcode uses).
  - In HAZ, one bubble is issued and stall_if=1; next cycle returns to RUN and the held instruction decodes with the write-back value forwarded.
- ex_stall=1: all ex_* outputs, FSM and flush_cnt hold; stall_if=1; br_taken is forced to 0 (a redirect never repeats).
- Priority: reset > ex_stall > flush > load-use hazard > normal decode.
- A taken BCOND arriving while flush_cnt>0 is squashed and does not branch.
- NOP (32'h0) decodes as ex_valid=0.

Decomposition:
- Package id_pkg: opcode constants; cond codes; field-position localparams; a typedef for the decode bundle (opcode, rd, op_a, op_b, reg_we, mem_rd, mem_wr).
- Sub-module id_cond_eval, combinational: cond[3:0] and flags[3:0] -> taken.
- Hazard FSM, forwarding and flush counter remain in id_stage.

Test Plan:
- Reset: hold reset 2 cycles with instr_in=ALU add -> all ex_* = 0 and stall_if=0; first bundle appears one cycle after reset falls.
- Forwarding: instr_in uses rs1=3, rs1_data=5, and in the same cycle write_enable=1, write_addr=3, write_value=0x77 -> ex_op_a=0x77.
- Load-use: LOAD rd=2, then ADD with rs1=2 -> cycle 2 is a bubble with stall_if=1; the ADD issues in cycle 3; one bubble total.
- Taken BCOND: pc_in=0x100, cond=EQ, flags Z=1, imm16=0xFFFE -> br_taken one cycle, br_target=0xF8; the next FLUSH_DEPTH instructions become bubbles.
- Not-taken BCOND: cond=EQ with Z=0 -> br_taken stays 0 and the next instruction issues normally.
- ex_stall for 3 cycles during a taken branch -> br_taken pulses exactly once and ex_* outputs stay unchanged across the stall.
